// File: rtl/rr_mux_arbiter_pkg.sv
// rr_arb_pkg: shared FSM state type, default sizing and one-hot helper for rr_mux_arbiter.
package rr_arb_pkg;
    typedef enum logic {IDLE, GRANT} state_e;
    localparam int DEF_N = 8;
    localparam int DEF_W = 4;
    localparam int MAX_N = 16;
    function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
        return MAX_N'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_mux_arbiter_prio_enc.sv
// prio_enc: lowest-set-bit priority encoder with an any-set flag.
module prio_enc #(
    parameter int N = 8,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    vec_i,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);
    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) if (vec_i[i]) idx_o = IDXW'(i);
    end
    assign any_o = |vec_i;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 mux arbiter with valid/ready output; RR_ARB_LOCK_EN enables grant locking.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_i,
    input  logic [N*W-1:0]  data_in_i,
    input  logic [N-1:0]    lock_i,
    input  logic            out_ready_i,
    output logic            out_valid_o,
    output logic [W-1:0]    out_data_o,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] gnt_idx_o
);
    state_e state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, m_idx, u_idx, win_idx;
    logic [N-1:0] gnt_q, gnt_d, masked;
    logic m_any, u_any, accept, hold;

    assign masked = req_i & ~((N'(1) << ptr_q) - N'(1));

    prio_enc #(.N(N)) u_masked (.vec_i(masked), .idx_o(m_idx), .any_o(m_any));
    prio_enc #(.N(N)) u_unmasked (.vec_i(req_i), .idx_o(u_idx), .any_o(u_any));

    assign win_idx = m_any ? m_idx : u_idx;
    assign accept = (state_q == GRANT) && out_ready_i;
`ifdef RR_ARB_LOCK_EN
    assign hold = lock_i[gnt_idx_q];
`else
    // Lock is still read so the port stays connected, but never holds the grant.
    assign hold = lock_i[gnt_idx_q] & 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        gnt_idx_d = gnt_idx_q;
        if (state_q == IDLE) begin
            if (u_any) begin
                state_d = GRANT;
                gnt_idx_d = win_idx;
                gnt_d = N'(onehot(4'(win_idx)));
            end
        end else if (accept && !hold) begin
            state_d = IDLE;
            gnt_d = '0;
            ptr_d = (gnt_idx_q == IDXW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
        end else if (!accept && !req_i[gnt_idx_q]) begin
            state_d = IDLE;
            gnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            gnt_q <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign out_valid_o = (state_q == GRANT);
    assign out_data_o = data_in_i[int'(gnt_idx_q) * W +: W];
    assign gnt_o = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of rr_mux_arbiter (N=4, W=4) against a transaction-level rotating-priority model.
module tb_rr_mux_arbiter;
    localparam int N = 4;
    localparam int W = 4;
`ifdef RR_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req;
    logic [N*W-1:0] data_in;
    logic [N-1:0] lock;
    logic out_ready;
    logic out_valid;
    logic [W-1:0] out_data;
    logic [N-1:0] gnt;
    logic [1:0] gnt_idx;

    int tests = 0;
    int fails = 0;
    int vcnt = 0;
    int acc_q[$];

    bit m_busy = 1'b0;
    int m_ptr = 0;
    int m_last = 0;

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req_i(req), .data_in_i(data_in), .lock_i(lock),
        .out_ready_i(out_ready), .out_valid_o(out_valid), .out_data_o(out_data),
        .gnt_o(gnt), .gnt_idx_o(gnt_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a grant is an owner index; the winner is the first requester found walking upward from ptr.
    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready) acc_q.push_back(int'(gnt_idx));
        if (rst) begin
            m_busy = 1'b0;
            m_ptr = 0;
            m_last = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++)
                if (!m_busy && req[(m_ptr + k) % N]) begin
                    m_busy = 1'b1;
                    m_last = (m_ptr + k) % N;
                end
        end else if (out_ready) begin
            if (!(LOCK && lock[m_last])) begin
                m_busy = 1'b0;
                m_ptr = (m_last + 1) % N;
            end
        end else if (!req[m_last]) m_busy = 1'b0;
    end

    always @(negedge clk) begin
        chk("model_gnt", int'(gnt), m_busy ? (1 << m_last) : 0);
        chk("model_gnt_idx", int'(gnt_idx), m_last);
        chk("model_valid", int'(out_valid), int'(m_busy));
        if (m_busy) chk("model_data", int'(out_data), int'((data_in >> (m_last * W)) & 16'hF));
        if (out_valid === 1'b1) vcnt++;
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_acc(input string name, input int exp[$]);
        chk({name, "_count"}, acc_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < acc_q.size(); i++) chk({name, "_order"}, acc_q[i], exp[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        lock = '0;
        out_ready = 1'b0;
        data_in = 16'h3A21;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_valid", int'(out_valid), 0);
            chk("rst_idx", int'(gnt_idx), 0);
        end
        rst = 1'b0;
        req = '0;
        chk("post_rst_gnt", int'(gnt), 0);
        chk("post_rst_valid", int'(out_valid), 0);
        cyc();
        chk("idle_gnt", int'(gnt), 0);

        req = 4'b0100;
        out_ready = 1'b1;
        cyc();
        chk("single_gnt", int'(gnt), 4'b0100);
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 4'hA);
        req = '0;
        cyc();
        chk("single_done_gnt", int'(gnt), 0);
        chk("single_done_valid", int'(out_valid), 0);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        acc_q.delete();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) cyc();
        req = '0;
        chk_acc("rotation", '{0, 1, 2, 3, 0});
        cyc();

        acc_q.delete();
        req = 4'b0010;
        out_ready = 1'b0;
        cyc();
        chk("abort_gnt", int'(gnt), 4'b0010);
        req = '0;
        cyc();
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_gnt_zero", int'(gnt), 0);
        chk("abort_idx_kept", int'(gnt_idx), 1);
        req = 4'b0110;
        out_ready = 1'b1;
        cyc();
        chk("abort_regrant", int'(gnt), 4'b0010);
        cyc();
        req = '0;
        chk_acc("abort_acc", '{1});
        cyc();

        acc_q.delete();
        vcnt = 0;
        req = 4'b0010;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("bp_gnt_stable", int'(gnt), 4'b0010);
        end
        out_ready = 1'b1;
        cyc();
        req = '0;
        chk("bp_valid_cycles", vcnt, 6);
        chk("bp_after_valid", int'(out_valid), 0);
        chk_acc("bp_acc", '{1});

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        acc_q.delete();
        req = 4'b1001;
        lock = 4'b0001;
        for (int i = 0; i < 3; i++) cyc();
        lock = '0;
        for (int i = 0; i < 3; i++) cyc();
        req = '0;
        cyc();
        if (LOCK) chk_acc("lock_acc", '{0, 0, 0, 3});
        else chk_acc("nolock_acc", '{0, 3, 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
